// File: rtl/x_pkt_rr_arbiter.sv
// x_pkt_rr_arbiter: packet-aware round-robin arbiter for one egress channel.
// The grant is locked from the first accepted beat of a packet until its last
// beat is accepted, so packets from different requesters never interleave.
// Optional build macro XARB_OUT_REG_EN: places a 2-entry skid buffer on the
// output, which gives 1-cycle latency while keeping full throughput.
module x_pkt_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req_vld,
  input  logic [N*DW-1:0]      req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_rdy,
  output logic                 out_vld,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_rdy,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(N);
  localparam logic [SW-1:0] MAX_IDX = SW'(N - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOCK} state_e;

  state_e        state_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] lock_q;
  logic          busy_q;

  logic          win_found;
  logic [SW-1:0] win_idx;
  int unsigned   cand;
  logic [SW-1:0] cidx;

  logic          grant_en;
  logic [SW-1:0] sel_idx;
  logic [SW-1:0] sel_nxt;
  logic          arb_vld;
  logic [DW-1:0] arb_data;
  logic          arb_last;
  logic [SW-1:0] arb_src;
  logic          arb_rdy;
  logic          xfer;

  // First valid requester at or above ptr_q, wrapping past N-1 to 0
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      cidx = cand[SW-1:0];
      if (!win_found && req_vld[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  // Select the visible requester: live winner in IDLE, locked source in LOCK
  always_comb begin
    grant_en = 1'b0;
    sel_idx  = '0;
    arb_vld  = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_en = win_found;
        sel_idx  = win_idx;
        arb_vld  = win_found;
      end
      S_LOCK: begin
        grant_en = 1'b1;
        sel_idx  = lock_q;
        arb_vld  = req_vld[lock_q];
      end
      default: ;
    endcase
    arb_data = arb_vld ? req_data[sel_idx*DW +: DW] : '0;
    arb_last = arb_vld & req_last[sel_idx];
    arb_src  = arb_vld ? sel_idx : '0;
    req_rdy  = '0;
    if (grant_en) req_rdy[sel_idx] = arb_rdy;
  end

  assign xfer    = arb_vld & arb_rdy;
  assign sel_nxt = (sel_idx == MAX_IDX) ? '0 : sel_idx + 1'b1;
  assign busy    = busy_q;

  // Arbitration FSM: lock on a non-last first beat, release and rotate on last
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      lock_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: state_q <= S_IDLE;
        S_IDLE: begin
          if (xfer) begin
            if (arb_last) begin
              ptr_q <= sel_nxt;
            end else begin
              state_q <= S_LOCK;
              lock_q  <= sel_idx;
              busy_q  <= 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (xfer && arb_last) begin
            state_q <= S_IDLE;
            ptr_q   <= sel_nxt;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

`ifdef XARB_OUT_REG_EN
  typedef struct packed {
    logic [SW-1:0] src;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t       skid0_q;
  beat_t       skid1_q;
  beat_t       head;
  logic        wr_q;
  logic        rd_q;
  logic [1:0]  cnt_q;
  logic        push;
  logic        pop;

  // The arbiter sees "skid not full" as its ready, cutting the out_rdy -> req_rdy path
  assign arb_rdy  = (cnt_q != 2'd2);
  assign push     = xfer;
  assign pop      = out_vld & out_rdy;
  assign head     = rd_q ? skid1_q : skid0_q;
  assign out_vld  = (cnt_q != 2'd0);
  assign out_data = head.data;
  assign out_last = head.last;
  assign out_src  = head.src;

  // Two-entry ring buffer; push and pop in the same cycle sustain one beat per cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid0_q <= '0;
      skid1_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (push) begin
        if (wr_q) skid1_q <= '{src: arb_src, last: arb_last, data: arb_data};
        else      skid0_q <= '{src: arb_src, last: arb_last, data: arb_data};
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: ;
      endcase
    end
  end
`else
  assign arb_rdy  = out_rdy;
  assign out_vld  = arb_vld;
  assign out_data = arb_data;
  assign out_last = arb_last;
  assign out_src  = arb_src;
`endif

endmodule
